// File: rtl/bound_flash_gen_if.sv
// ---------------------------------------------------------------------------
// bound_flash_gen_if
//   Bundles the request input and the LED/status outputs of bound_flash_gen.
//
//   Signals:
//     flick  start / kickback request (driven by the switch side)
//     out    N_LED thermometer bar, out[i]=1 iff i < level
//     level  current lit count
//     state  0=IDLE, 1=UP, 2=DOWN, 3=FINAL
//     phase  current phase (0 while idle, 1..K while running)
//     done   one-cycle pulse on return to IDLE
//
//   Modports:
//     master  the side that issues flick and observes the bar
//     slave   the controller itself
// ---------------------------------------------------------------------------
interface bound_flash_gen_if #(
    parameter int N_LED = 15,
    parameter int SEG   = 5
);
    localparam int K  = N_LED / SEG;
    localparam int LW = $clog2(N_LED + 1);
    localparam int PW = $clog2(K + 1);

    logic              flick;
    logic [N_LED-1:0]  out;
    logic [LW-1:0]     level;
    logic [1:0]        state;
    logic [PW-1:0]     phase;
    logic              done;

    modport master (
        output flick,
        input  out, level, state, phase, done
    );

    modport slave (
        input  flick,
        output out, level, state, phase, done
    );
endinterface

// File: rtl/bound_flash_gen.sv
// ---------------------------------------------------------------------------
// bound_flash_gen
//   Multi-phase bounce-flash controller for an N_LED thermometer bar.
//   A flick starts a run: phase p fills the bar up to p*SEG and drains it
//   back to max(p-2,0)*SEG, for p = 1..K (K = N_LED/SEG). After the last
//   fill the bar drains fully to zero and done pulses. A flick seen when
//   the rising bar crosses an intermediate segment boundary kicks it back
//   down without advancing the phase.
//
//   Ports:
//     clk    system clock, rising edge
//     reset  asynchronous active-high reset
//     bus    bound_flash_gen_if.slave (flick in; out/level/state/phase/done)
//
//   Parameters:
//     N_LED        bar length, multiple of SEG and >= 2*SEG
//     SEG          segment length
//     DIV          clk cycles per step tick (>= 1)
//     FLICK_LATCH  0: flick sampled on the tick itself
//                  1: any flick cycle since the last decision counts
// ---------------------------------------------------------------------------
module bound_flash_gen #(
    parameter int N_LED       = 15,
    parameter int SEG         = 5,
    parameter int DIV         = 1,
    parameter int FLICK_LATCH = 0
) (
    input  logic                clk,
    input  logic                reset,
    bound_flash_gen_if.slave    bus
);
    localparam int K  = N_LED / SEG;
    localparam int LW = $clog2(N_LED + 1);
    localparam int PW = $clog2(K + 1);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        UP    = 2'd1,
        DOWN  = 2'd2,
        FINAL = 2'd3
    } state_t;

    state_t            st;
    logic [LW-1:0]     lvl;
    logic [PW-1:0]     ph;
    logic              done_r;
    logic [N_LED-1:0]  out_r;
    logic              latch;
    logic [CW-1:0]     pcnt;

    logic              tick;
    logic              flick_eff;
    int                lvl_up;
    int                lvl_dn;
    int                peak;
    int                flr;
    logic              at_peak;
    logic              at_bound;

    // Lowest level of the drain in phase p.
    function automatic int floor_of(input int p);
        return ((p > 2) ? (p - 2) : 0) * SEG;
    endfunction

    // Highest level of the fill in phase p.
    function automatic int peak_of(input int p);
        return p * SEG;
    endfunction

    function automatic logic [N_LED-1:0] therm(input int n);
        logic [N_LED-1:0] t;
        for (int i = 0; i < N_LED; i++) begin
            t[i] = (i < n);
        end
        return t;
    endfunction

    assign tick      = (pcnt == CW'(DIV - 1));
    assign flick_eff = bus.flick | ((FLICK_LATCH != 0) && latch);

    always_comb begin
        lvl_up   = int'(lvl) + 1;
        lvl_dn   = int'(lvl) - 1;
        peak     = peak_of(int'(ph));
        flr      = floor_of(int'(ph));
        at_peak  = (lvl_up == peak);
        // Strictly inside the current fill range; in phase 1 the range
        // (0, SEG) holds no multiple of SEG, so no boundary ever fires there.
        at_bound = ((lvl_up % SEG) == 0) && (lvl_up > flr) && (lvl_up < peak);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st     <= IDLE;
            lvl    <= '0;
            ph     <= '0;
            done_r <= 1'b0;
            out_r  <= '0;
            latch  <= 1'b0;
            pcnt   <= '0;
        end else begin
            done_r <= 1'b0;
            pcnt   <= tick ? '0 : pcnt + 1'b1;

            // Capture first; a decision tick below clears it and takes priority.
            if ((FLICK_LATCH != 0) && bus.flick) begin
                latch <= 1'b1;
            end

            if (tick) begin
                case (st)
                    IDLE: begin
                        latch <= 1'b0;
                        if (flick_eff) begin
                            st <= UP;
                            ph <= PW'(1);
                        end
                    end

                    UP: begin
                        if (lvl_up <= N_LED) begin
                            lvl   <= lvl + 1'b1;
                            out_r <= therm(lvl_up);
                            if (at_peak) begin
                                if (int'(ph) < K) begin
                                    st <= DOWN;
                                    ph <= ph + 1'b1;
                                end else begin
                                    st <= FINAL;
                                end
                            end else if (at_bound) begin
                                latch <= 1'b0;
                                if (flick_eff) begin
                                    st <= DOWN;
                                end
                            end
                        end
                    end

                    DOWN: begin
                        if (lvl != '0) begin
                            lvl   <= lvl - 1'b1;
                            out_r <= therm(lvl_dn);
                            if (lvl_dn == flr) begin
                                st <= UP;
                            end
                        end
                    end

                    FINAL: begin
                        if (lvl != '0) begin
                            lvl   <= lvl - 1'b1;
                            out_r <= therm(lvl_dn);
                            if (lvl_dn == 0) begin
                                st     <= IDLE;
                                ph     <= '0;
                                done_r <= 1'b1;
                            end
                        end
                    end

                    default: st <= IDLE;
                endcase
            end
        end
    end

    assign bus.out   = out_r;
    assign bus.level = lvl;
    assign bus.state = st;
    assign bus.phase = ph;
    assign bus.done  = done_r;

endmodule

// File: tb/tb_bound_flash_gen.sv
// ---------------------------------------------------------------------------
// tb_bound_flash_gen
//   Directed bench for bound_flash_gen. Three instances share clk/reset:
//     a: N_LED=15 SEG=5 DIV=1 FLICK_LATCH=0
//     b: N_LED=15 SEG=5 DIV=4 FLICK_LATCH=1
//     c: N_LED=15 SEG=5 DIV=4 FLICK_LATCH=0
// ---------------------------------------------------------------------------
module tb_bound_flash_gen;
    logic clk;
    logic reset;

    int vectors;
    int errors;

    // Expected step tables (flick value to apply before each edge, and the
    // outputs required after that edge).
    logic [3:0] q_lvl[$];
    logic [1:0] q_st[$];
    logic [1:0] q_ph[$];
    logic       q_dn[$];
    logic       q_fl[$];

    bound_flash_gen_if #(.N_LED(15), .SEG(5)) ifa();
    bound_flash_gen_if #(.N_LED(15), .SEG(5)) ifb();
    bound_flash_gen_if #(.N_LED(15), .SEG(5)) ifc();

    bound_flash_gen #(.N_LED(15), .SEG(5), .DIV(1), .FLICK_LATCH(0)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa)
    );
    bound_flash_gen #(.N_LED(15), .SEG(5), .DIV(4), .FLICK_LATCH(1)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb)
    );
    bound_flash_gen #(.N_LED(15), .SEG(5), .DIV(4), .FLICK_LATCH(0)) dut_c (
        .clk(clk), .reset(reset), .bus(ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] bar(input logic [3:0] l);
        return (15'd1 << l) - 15'd1;
    endfunction

    task automatic clear_q();
        q_lvl.delete(); q_st.delete(); q_ph.delete(); q_dn.delete(); q_fl.delete();
    endtask

    task automatic push(input int l, input int s, input int p, input int d, input int f);
        q_lvl.push_back(4'(l));
        q_st.push_back(2'(s));
        q_ph.push_back(2'(p));
        q_dn.push_back(d != 0);
        q_fl.push_back(f != 0);
    endtask

    // Full single-flick run; optional kickback when phase 3 climbs to 10.
    task automatic build_run(input bit kick3);
        clear_q();
        push(0, 1, 1, 0, 1);
        for (int l = 1; l <= 4; l++) push(l, 1, 1, 0, 0);
        push(5, 2, 2, 0, 0);
        for (int l = 4; l >= 1; l--) push(l, 2, 2, 0, 0);
        push(0, 1, 2, 0, 0);
        for (int l = 1; l <= 9; l++) push(l, 1, 2, 0, 0);
        push(10, 2, 3, 0, 0);
        for (int l = 9; l >= 6; l--) push(l, 2, 3, 0, 0);
        push(5, 1, 3, 0, 0);
        if (kick3) begin
            for (int l = 6; l <= 9; l++) push(l, 1, 3, 0, 0);
            push(10, 2, 3, 0, 1);
            for (int l = 9; l >= 6; l--) push(l, 2, 3, 0, 0);
            push(5, 1, 3, 0, 0);
        end
        for (int l = 6; l <= 14; l++) push(l, 1, 3, 0, 0);
        push(15, 3, 3, 0, 0);
        for (int l = 14; l >= 1; l--) push(l, 3, 3, 0, 0);
        push(0, 0, 0, 1, 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        ifa.flick = 1'b0; ifb.flick = 1'b0; ifc.flick = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ifa.flick = 1'b0; ifb.flick = 1'b0; ifc.flick = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (ifa.level !== 4'd0 || ifa.out !== 15'd0 || ifa.state !== 2'd0 ||
            ifa.phase !== 2'd0 || ifa.done !== 1'b0 ||
            ifb.state !== 2'd0 || ifc.state !== 2'd0) begin
            errors++;
            $display("FAIL reset_hold: a level=%0d out=%h state=%0d phase=%0d done=%b b.state=%0d c.state=%0d, want all 0",
                     ifa.level, ifa.out, ifa.state, ifa.phase, ifa.done, ifb.state, ifc.state);
        end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); @(negedge clk);
            vectors++;
            if (ifa.level !== 4'd0 || ifa.out !== 15'd0 || ifa.state !== 2'd0 || ifa.done !== 1'b0) begin
                errors++;
                $display("FAIL idle_quiet cycle %0d: level=%0d out=%h state=%0d done=%b, want 0/0/0/0",
                         i, ifa.level, ifa.out, ifa.state, ifa.done);
            end
        end
    endtask

    task automatic test_single_pulse();
        int ndone;
        apply_reset();
        build_run(1'b0);
        ndone = 0;
        for (int i = 0; i < q_lvl.size(); i++) begin
            ifa.flick = q_fl[i];
            @(posedge clk); @(negedge clk);
            if (ifa.done === 1'b1) ndone++;
            vectors++;
            if (ifa.level !== q_lvl[i] || ifa.out !== bar(q_lvl[i]) || ifa.state !== q_st[i] ||
                ifa.phase !== q_ph[i] || ifa.done !== q_dn[i]) begin
                errors++;
                $display("FAIL single_pulse step %0d: level=%0d out=%h state=%0d phase=%0d done=%b, want level=%0d out=%h state=%0d phase=%0d done=%b",
                         i, ifa.level, ifa.out, ifa.state, ifa.phase, ifa.done,
                         q_lvl[i], bar(q_lvl[i]), q_st[i], q_ph[i], q_dn[i]);
            end
        end
        ifa.flick = 1'b0;
        @(posedge clk); @(negedge clk);
        if (ifa.done === 1'b1) ndone++;
        vectors++;
        if (ifa.done !== 1'b0 || ifa.state !== 2'd0 || ndone != 1) begin
            errors++;
            $display("FAIL single_pulse_after: done=%b state=%0d done_count=%0d, want done=0 state=0 done_count=1",
                     ifa.done, ifa.state, ndone);
        end
    endtask

    task automatic test_flick_held();
        apply_reset();
        clear_q();
        push(0, 1, 1, 0, 1);
        for (int l = 1; l <= 4; l++) push(l, 1, 1, 0, 1);
        push(5, 2, 2, 0, 1);
        for (int r = 0; r < 3; r++) begin
            for (int l = 4; l >= 1; l--) push(l, 2, 2, 0, 1);
            push(0, 1, 2, 0, 1);
            for (int l = 1; l <= 4; l++) push(l, 1, 2, 0, 1);
            push(5, 2, 2, 0, 1);
        end
        for (int i = 0; i < q_lvl.size(); i++) begin
            ifa.flick = q_fl[i];
            @(posedge clk); @(negedge clk);
            vectors++;
            if (ifa.level !== q_lvl[i] || ifa.out !== bar(q_lvl[i]) || ifa.state !== q_st[i] ||
                ifa.phase !== q_ph[i] || ifa.done !== q_dn[i]) begin
                errors++;
                $display("FAIL flick_held step %0d: level=%0d state=%0d phase=%0d done=%b, want level=%0d state=%0d phase=%0d done=%b",
                         i, ifa.level, ifa.state, ifa.phase, ifa.done,
                         q_lvl[i], q_st[i], q_ph[i], q_dn[i]);
            end
        end
        ifa.flick = 1'b0;
    endtask

    task automatic test_kickback_p3();
        apply_reset();
        build_run(1'b1);
        for (int i = 0; i < q_lvl.size(); i++) begin
            ifa.flick = q_fl[i];
            @(posedge clk); @(negedge clk);
            vectors++;
            if (ifa.level !== q_lvl[i] || ifa.out !== bar(q_lvl[i]) || ifa.state !== q_st[i] ||
                ifa.phase !== q_ph[i] || ifa.done !== q_dn[i]) begin
                errors++;
                $display("FAIL kickback_p3 step %0d: level=%0d state=%0d phase=%0d done=%b, want level=%0d state=%0d phase=%0d done=%b",
                         i, ifa.level, ifa.state, ifa.phase, ifa.done,
                         q_lvl[i], q_st[i], q_ph[i], q_dn[i]);
            end
        end
        ifa.flick = 1'b0;
    endtask

    // Prescaler released with reset; ticks fall on edges 4, 8, 12.
    // The pulse covers edge 2 only, which is not a tick.
    task automatic test_prescaler_latch();
        logic [1:0] eb_st;
        logic [3:0] eb_lvl;
        apply_reset();
        for (int n = 1; n <= 12; n++) begin
            ifb.flick = (n == 2);
            ifc.flick = (n == 2);
            @(posedge clk); @(negedge clk);
            if (n < 4)       begin eb_st = 2'd0; eb_lvl = 4'd0; end
            else if (n < 8)  begin eb_st = 2'd1; eb_lvl = 4'd0; end
            else if (n < 12) begin eb_st = 2'd1; eb_lvl = 4'd1; end
            else             begin eb_st = 2'd1; eb_lvl = 4'd2; end
            vectors++;
            if (ifb.state !== eb_st || ifb.level !== eb_lvl || ifb.out !== bar(eb_lvl)) begin
                errors++;
                $display("FAIL latch_start edge %0d: state=%0d level=%0d out=%h, want state=%0d level=%0d out=%h",
                         n, ifb.state, ifb.level, ifb.out, eb_st, eb_lvl, bar(eb_lvl));
            end
            vectors++;
            if (ifc.state !== 2'd0 || ifc.level !== 4'd0) begin
                errors++;
                $display("FAIL nolatch_idle edge %0d: state=%0d level=%0d, want state=0 level=0",
                         n, ifc.state, ifc.level);
            end
        end
        ifb.flick = 1'b0;
        ifc.flick = 1'b0;
    endtask

    task automatic test_async_reset();
        apply_reset();
        ifa.flick = 1'b1;
        @(posedge clk); @(negedge clk);
        ifa.flick = 1'b0;
        repeat (18) begin
            @(posedge clk); @(negedge clk);
        end
        vectors++;
        if (ifa.level !== 4'd8 || ifa.state !== 2'd1 || ifa.phase !== 2'd2) begin
            errors++;
            $display("FAIL async_setup: level=%0d state=%0d phase=%0d, want level=8 state=1 phase=2",
                     ifa.level, ifa.state, ifa.phase);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (ifa.level !== 4'd0 || ifa.out !== 15'd0 || ifa.state !== 2'd0 ||
            ifa.phase !== 2'd0 || ifa.done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: level=%0d out=%h state=%0d phase=%0d done=%b, want all 0",
                     ifa.level, ifa.out, ifa.state, ifa.phase, ifa.done);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); @(negedge clk);
        vectors++;
        if (ifa.level !== 4'd0 || ifa.state !== 2'd0) begin
            errors++;
            $display("FAIL after_async_reset: level=%0d state=%0d, want level=0 state=0",
                     ifa.level, ifa.state);
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        reset   = 1'b1;
        ifa.flick = 1'b0; ifb.flick = 1'b0; ifc.flick = 1'b0;
        test_reset();
        test_single_pulse();
        test_flick_held();
        test_kickback_p3();
        test_prescaler_latch();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
